// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer
//   Debug run controller that sits between the monitor command path and the
//   CPU status block. RUN / STOP / STEP-N / RUN-TO-BREAKPOINT commands become
//   single-cycle cpu_start / quit_cmd pulses. The block counts retirements in
//   step mode, compares retire PCs against NUM_BP breakpoint slots, and reports
//   why each run sequence ended.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (see below)
//   cmd_op, cmd_arg    0 NOP, 1 RUN, 2 STOP, 3 STEP(arg), 4 RUN_BP, 5-7 NOP
//   bp_wr/idx/addr/en  breakpoint slot write port, usable in any state
//   cpu_run_state      run flag returned by the status block
//   retire_valid/pc    one retirement per cycle with its PC
//   cpu_start/quit_cmd one-cycle pulses to the status block
//   seq_state          FSM state (IDLE=0 START=1 RUN=2 STEP=3 STOPPING=4)
//   halt_evt           one-cycle pulse when a run sequence ends
//   halt_reason        0 NONE 1 STOP 2 STEP_DONE 3 BP_HIT 4 EXT, held until next halt_evt
//   hit_bp             lowest matching slot for BP_HIT
//   step_remain        steps left in step mode
//
// Handshake: a command transfers in a cycle where cmd_valid and cmd_ready are
// both 1. cmd_ready depends only on the FSM state (1 in IDLE, RUN, STEP), never
// on cmd_valid, so the producer may hold cmd_valid until it sees cmd_ready.
module cpu_run_sequencer #(
  parameter int PC_W   = 30,
  parameter int STEP_W = 16,
  parameter int NUM_BP = 2,
  parameter int BPI_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_wr,
  input  logic [BPI_W-1:0]  bp_idx,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_en,
  input  logic              cpu_run_state,
  input  logic              retire_valid,
  input  logic [PC_W-1:0]   retire_pc,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic [2:0]        seq_state,
  output logic              halt_evt,
  output logic [2:0]        halt_reason,
  output logic [BPI_W-1:0]  hit_bp,
  output logic [STEP_W-1:0] step_remain
);

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STOP   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RUN_BP = 3'd4;

  localparam logic [2:0] R_STOP = 3'd1;
  localparam logic [2:0] R_STEP = 3'd2;
  localparam logic [2:0] R_BP   = 3'd3;
  localparam logic [2:0] R_EXT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RUN      = 3'd2,
    S_STEP     = 3'd3,
    S_STOPPING = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                cpu_start_q, cpu_start_d;
  logic                quit_cmd_q, quit_cmd_d;
  logic                halt_evt_q, halt_evt_d;
  logic [2:0]          halt_reason_q, halt_reason_d;
  logic [BPI_W-1:0]    hit_bp_q, hit_bp_d;
  logic [STEP_W-1:0]   step_remain_q, step_remain_d;
  logic                step_mode_q, step_mode_d;
  logic                bp_armed_q, bp_armed_d;
  // Reason/slot captured at the stop trigger, published on halt_evt.
  logic [2:0]          pend_reason_q, pend_reason_d;
  logic [BPI_W-1:0]    pend_bp_q, pend_bp_d;

  logic [PC_W-1:0]     bp_addr_q [NUM_BP];
  logic [PC_W-1:0]     bp_addr_d [NUM_BP];
  logic [NUM_BP-1:0]   bp_en_q, bp_en_d;

  logic                cmd_acc;
  logic                match_any;
  logic [BPI_W-1:0]    match_idx;
  logic                bp_hit;
  logic                step_done;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_STEP);
  assign cmd_acc   = cmd_valid && cmd_ready;

  // Breakpoint slot writes land next cycle; out-of-range indices are dropped.
  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_wr && (32'(bp_idx) == i)) begin
        bp_addr_d[i] = bp_addr;
        bp_en_d[i]   = bp_en;
      end
    end
  end

  // Scan downwards so the lowest matching slot is the last one written.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == retire_pc)) begin
        match_any = 1'b1;
        match_idx = BPI_W'(i);
      end
    end
  end

  assign bp_hit    = retire_valid && bp_armed_q && match_any;
  assign step_done = step_mode_q && retire_valid && (step_remain_q == STEP_W'(1));

  always_comb begin
    state_d       = state_q;
    cpu_start_d   = 1'b0;
    quit_cmd_d    = 1'b0;
    halt_evt_d    = 1'b0;
    halt_reason_d = halt_reason_q;
    hit_bp_d      = hit_bp_q;
    step_remain_d = step_remain_q;
    step_mode_d   = step_mode_q;
    bp_armed_d    = bp_armed_q;
    pend_reason_d = pend_reason_q;
    pend_bp_d     = pend_bp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN, OP_RUN_BP: begin
              state_d       = S_START;
              cpu_start_d   = 1'b1;
              bp_armed_d    = (cmd_op == OP_RUN_BP);
              step_mode_d   = 1'b0;
              step_remain_d = '0;
            end
            OP_STEP: begin
              if (cmd_arg != '0) begin
                state_d       = S_START;
                cpu_start_d   = 1'b1;
                bp_armed_d    = 1'b1;
                step_mode_d   = 1'b1;
                step_remain_d = cmd_arg;
              end else begin
                // Zero-length step completes without starting the CPU.
                halt_evt_d    = 1'b1;
                halt_reason_d = R_STEP;
                hit_bp_d      = '0;
              end
            end
            OP_STOP: begin
              halt_evt_d    = 1'b1;
              halt_reason_d = R_STOP;
              hit_bp_d      = '0;
            end
            default: ;
          endcase
        end
      end

      S_START, S_RUN, S_STEP: begin
        if (step_mode_q && retire_valid && (step_remain_q != '0))
          step_remain_d = step_remain_q - STEP_W'(1);

        // Priority: breakpoint > step done > STOP command > external halt.
        if (bp_hit || step_done) begin
          state_d       = S_STOPPING;
          quit_cmd_d    = 1'b1;
          pend_reason_d = bp_hit ? R_BP : R_STEP;
          pend_bp_d     = bp_hit ? match_idx : '0;
        end else if (cmd_acc && (cmd_op == OP_STOP)) begin
          state_d       = S_STOPPING;
          quit_cmd_d    = 1'b1;
          pend_reason_d = R_STOP;
          pend_bp_d     = '0;
        end else if (state_q == S_START) begin
          if (cpu_run_state)
            state_d = step_mode_q ? S_STEP : S_RUN;
        end else if (!cpu_run_state) begin
          // CPU stopped on its own: no quit is sent.
          state_d       = S_IDLE;
          halt_evt_d    = 1'b1;
          halt_reason_d = R_EXT;
          hit_bp_d      = '0;
        end
      end

      S_STOPPING: begin
        if (!cpu_run_state) begin
          state_d       = S_IDLE;
          halt_evt_d    = 1'b1;
          halt_reason_d = pend_reason_q;
          hit_bp_d      = pend_bp_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cpu_start_q   <= 1'b0;
      quit_cmd_q    <= 1'b0;
      halt_evt_q    <= 1'b0;
      halt_reason_q <= '0;
      hit_bp_q      <= '0;
      step_remain_q <= '0;
      step_mode_q   <= 1'b0;
      bp_armed_q    <= 1'b0;
      pend_reason_q <= '0;
      pend_bp_q     <= '0;
      bp_en_q       <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cpu_start_q   <= cpu_start_d;
      quit_cmd_q    <= quit_cmd_d;
      halt_evt_q    <= halt_evt_d;
      halt_reason_q <= halt_reason_d;
      hit_bp_q      <= hit_bp_d;
      step_remain_q <= step_remain_d;
      step_mode_q   <= step_mode_d;
      bp_armed_q    <= bp_armed_d;
      pend_reason_q <= pend_reason_d;
      pend_bp_q     <= pend_bp_d;
      bp_en_q       <= bp_en_d;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= bp_addr_d[i];
    end
  end

  assign cpu_start   = cpu_start_q;
  assign quit_cmd    = quit_cmd_q;
  assign halt_evt    = halt_evt_q;
  assign halt_reason = halt_reason_q;
  assign hit_bp      = hit_bp_q;
  assign step_remain = step_remain_q;
  assign seq_state   = state_q;

endmodule
